// File: rtl/bram_fwft_fifo_if.sv
// Producer/consumer bundle for the first-word-fall-through BRAM FIFO.
// The master side pushes and pops; the slave side is the FIFO itself.
interface bram_fwft_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] src_data;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dest_data;
    logic                  dest_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  wr_err_flr;
    logic                  rd_err_flr;
    logic [ADDR_WIDTH:0]   data_cnt;

    modport master (
        output src_data, wr_en, rd_en,
        input  dest_data, dest_valid, empty, full,
        input  almost_full, almost_empty,
        input  wr_err_flr, rd_err_flr, data_cnt
    );

    modport slave (
        input  src_data, wr_en, rd_en,
        output dest_data, dest_valid, empty, full,
        output almost_full, almost_empty,
        output wr_err_flr, rd_err_flr, data_cnt
    );
endinterface

// File: rtl/bram_fwft_fifo.sv
// FWFT FIFO over a registered-read block RAM with a two-slot prefetch
// pipe (RAM output stage + output register) for 1 word/cycle streaming.
module bram_fwft_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bram_fwft_fifo_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] INC      = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   occ;
    logic                  ram_v_q, ram_v_d;
    logic                  dv_q, dv_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_err_q, rd_err_d;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  fetch;
    logic                  advance;
    logic [1:0]            slots;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [ADDR_WIDTH-1:0] write_addr;

    // Handshake qualification and prefetch decision for this cycle
    always_comb begin
        full       = (cnt_q == DEPTH_C);
        push       = bus.wr_en && !full;
        pop        = bus.rd_en && dv_q;
        occ        = wr_ptr_q - rd_ptr_q;
        slots      = {1'b0, dv_q} + {1'b0, ram_v_q} - {1'b0, pop};
        fetch      = (occ != '0) && (slots < 2'd2);
        advance    = ram_v_q && (!dv_q || pop);
        read_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
        write_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    end

    // Next-state for pointers, prefetch slots, count and error pulses
    always_comb begin
        wr_ptr_d = push  ? wr_ptr_q + INC : wr_ptr_q;
        rd_ptr_d = fetch ? rd_ptr_q + INC : rd_ptr_q;
        ram_v_d  = fetch || (ram_v_q && !advance);
        dv_d     = advance || (dv_q && !pop);
        dout_d   = advance ? ram_q : dout_q;
        wr_err_d = bus.wr_en && full;
        rd_err_d = bus.rd_en && !dv_q;
        unique case (1'b1)
            push && !pop: cnt_d = cnt_q + INC;
            pop && !push: cnt_d = cnt_q - INC;
            default:      cnt_d = cnt_q;
        endcase
    end

    // RAM array and its registered read port; contents survive reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[write_addr] <= bus.src_data;
        end
        if (fetch) begin
            ram_q <= mem[read_addr];
        end
    end

    // Control state; reset drops any in-flight fetch and the head word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ram_v_q  <= 1'b0;
            dv_q     <= 1'b0;
            dout_q   <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ram_v_q  <= ram_v_d;
            dv_q     <= dv_d;
            dout_q   <= dout_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign bus.dest_data    = dout_q;
    assign bus.dest_valid   = dv_q;
    assign bus.empty        = !dv_q;
    assign bus.full         = full;
    assign bus.almost_full  = (cnt_q >= AFULL_C);
    assign bus.almost_empty = (cnt_q <= AEMPTY_C);
    assign bus.wr_err_flr   = wr_err_q;
    assign bus.rd_err_flr   = rd_err_q;
    assign bus.data_cnt     = cnt_q;
endmodule
